// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, FSM states and GF(2^8) helpers for the
// inverse round datapath.
package aes_pkg;

    localparam int unsigned NB         = 4;
    localparam int unsigned NR_DEFAULT = 10;

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (used with 9, 11, 13, 14) via an xtime chain.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[3] ? x8 : 8'h00);
    endfunction

    // Row n of each column rotates right by n columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        w0 = s[127:96];
        w1 = s[95:64];
        w2 = s[63:32];
        w3 = s[31:0];
        return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
                w1[31:24], w0[23:16], w3[15:8], w2[7:0],
                w2[31:24], w1[23:16], w0[15:8], w3[7:0],
                w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            r[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_cipher_seq_if.sv
// Block-in / block-out handshake plus round-key fetch port of the inverse cipher.
interface inv_cipher_seq_if;

    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] data_i;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] data_o;
    logic         busy_o;

    modport slave (
        input  in_valid_i, data_i, rk_i, out_ready_i,
        output in_ready_o, rk_idx_o, out_valid_o, data_o, busy_o
    );

    modport master (
        output in_valid_i, data_i, rk_i, out_ready_i,
        input  in_ready_o, rk_idx_o, out_valid_o, data_o, busy_o
    );

endinterface

// File: rtl/inv_subbytes.sv
// 128-bit InvSubBytes: sixteen copies of the inverse S-box table.
module inv_subbytes (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] s;
        case (b)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5;
            8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e;
            8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82;
            8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44;
            8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32;
            8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b;
            8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66;
            8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49;
            8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64;
            8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc;
            8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50;
            8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57;
            8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00;
            8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05;
            8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f;
            8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03;
            8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41;
            8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce;
            8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22;
            8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8;
            8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71;
            8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e;
            8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b;
            8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe;
            8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33;
            8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59;
            8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9;
            8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f;
            8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d;
            8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c;
            8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e;
            8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63;
            8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c;
            default: s = 8'h7d;
        endcase
        return s;
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
    end

endmodule

// File: rtl/inv_cipher_seq.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by
// index from the shared expanded-key store.
module inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    inv_cipher_seq_if.slave   bus
);

    state_e       fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [127:0] isr, isb, core;

    assign isr = inv_shift_rows(state_q);

    inv_subbytes u_inv_subbytes (
        .data_i (isr),
        .data_o (isb)
    );

    assign core = isb ^ bus.rk_i;

    // Outputs decode from registered state only.
    assign bus.in_ready_o  = (fsm_q == StIdle);
    assign bus.out_valid_o = (fsm_q == StDone);
    assign bus.busy_o      = (fsm_q != StIdle);
    assign bus.rk_idx_o    = (fsm_q == StRound) ? rnd_q : 4'(NR);
    assign bus.data_o      = state_q;

    // Next-state: whitening on accept, one round per ROUND cycle, hold in DONE.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            StIdle: begin
                if (bus.in_valid_i) begin
                    state_d = bus.data_i ^ bus.rk_i;
                    rnd_d   = 4'(NR - 1);
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                if (rnd_q != 4'd0) begin
                    state_d = inv_mix_columns(core);
                    rnd_d   = rnd_q - 4'd1;
                end else begin
                    // Final round skips InvMixColumns.
                    state_d = core;
                    fsm_d   = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready_i) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            rnd_q   <= 4'(NR - 1);
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: tb/tb_inv_cipher_seq.sv
// Directed bench for inv_cipher_seq using FIPS-197 vectors and a local
// key-expansion model that feeds round keys by index.
module tb_inv_cipher_seq;
    import aes_pkg::*;

    localparam int unsigned NR = 10;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic reset_i;
    int   n_err;
    int   n_checks;
    int   overlap;

    logic [7:0]   sbox   [0:255];
    logic [127:0] rk_mem [0:15];

    inv_cipher_seq_if bus ();

    inv_cipher_seq #(.NR(NR)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    assign bus.rk_i = rk_mem[bus.rk_idx_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count any cycle where both handshake outputs are high.
    always @(negedge clk) begin
        if (bus.in_ready_o && bus.out_valid_o) overlap <= overlap + 1;
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from its definition: GF inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int xi = 0; xi < 256; xi++) begin
            x   = 8'(xi);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[xi] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^
                     {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        for (int r = 0; r <= 10; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Offer one block from IDLE, follow it through every round, then drain it
    // after 'hold' back-pressured DONE cycles.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                             input int hold, input bit pulse);
        int cycles;
        chk_bit({tag, "_in_ready"}, bus.in_ready_o, 1'b1);
        chk_int({tag, "_idx_idle"}, int'(bus.rk_idx_o), NR);
        bus.data_i     = ct;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        cycles = 0;
        while (bus.out_valid_o !== 1'b1 && cycles < 4 * NR) begin
            chk_int({tag, "_idx_round"}, int'(bus.rk_idx_o), NR - 1 - cycles);
            if (cycles == 0) chk_bit({tag, "_busy"}, bus.busy_o, 1'b1);
            if (pulse && (cycles == 3 || cycles == 7)) begin
                bus.in_valid_i = 1'b1;
                bus.data_i     = ~ct;
            end else begin
                bus.in_valid_i = 1'b0;
            end
            tick();
            cycles++;
        end
        bus.in_valid_i = 1'b0;
        chk_int({tag, "_latency"}, cycles, NR);
        chk_blk({tag, "_data"}, bus.data_o, pt);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk_blk({tag, "_hold_data"}, bus.data_o, pt);
            chk_bit({tag, "_hold_ready"}, bus.in_ready_o, 1'b0);
            chk_bit({tag, "_hold_valid"}, bus.out_valid_o, 1'b1);
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk_bit({tag, "_rel_ready"}, bus.in_ready_o, 1'b1);
        chk_bit({tag, "_rel_valid"}, bus.out_valid_o, 1'b0);
    endtask

    initial begin
        int cycles;
        int seen;
        n_err          = 0;
        n_checks       = 0;
        overlap        = 0;
        reset_i        = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.data_i     = '0;
        build_sbox();
        expand_key(C1_KEY);

        // Reset values.
        tick();
        chk_bit("rst_in_ready", bus.in_ready_o, 1'b1);
        chk_bit("rst_out_valid", bus.out_valid_o, 1'b0);
        chk_bit("rst_busy", bus.busy_o, 1'b0);
        chk_blk("rst_data", bus.data_o, '0);
        chk_int("rst_idx", int'(bus.rk_idx_o), NR);
        #2 reset_i = 1'b0;
        tick();

        // App. C.1 vector with key-index sequence and latency.
        run_block("c1", C1_CT, C1_PT, 0, 1'b0);

        // App. B vector under back-pressure, then an immediate C.1 block.
        expand_key(B_KEY);
        run_block("b_bp", B_CT, B_PT, 5, 1'b0);
        expand_key(C1_KEY);
        run_block("c1_b2b", C1_CT, C1_PT, 0, 1'b0);

        // Busy-input rejection; no second result may follow.
        run_block("c1_busy", C1_CT, C1_PT, 0, 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid_o) seen++;
        end
        chk_int("busy_no_second", seen, 0);

        // Asynchronous reset at r=5.
        bus.data_i     = C1_CT;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        cycles = 0;
        while (bus.rk_idx_o !== 4'd5 && cycles < 20) begin
            tick();
            cycles++;
        end
        chk_int("mid_reach_r5", int'(bus.rk_idx_o), 5);
        #3 reset_i = 1'b1;
        #1;
        chk_bit("mid_rst_out_valid", bus.out_valid_o, 1'b0);
        chk_bit("mid_rst_in_ready", bus.in_ready_o, 1'b1);
        chk_blk("mid_rst_data", bus.data_o, '0);
        chk_bit("mid_rst_busy", bus.busy_o, 1'b0);
        chk_int("mid_rst_idx", int'(bus.rk_idx_o), NR);
        @(posedge clk);
        #2 reset_i = 1'b0;
        tick();
        expand_key(B_KEY);
        run_block("b_after_rst", B_CT, B_PT, 0, 1'b0);

        // InvMixColumns package function.
        chk_int("imc_8e4da1bc", int'(inv_mix_column(32'h8e4da1bc)), int'(32'hdb135345));
        chk_int("imc_9fdc589d", int'(inv_mix_column(32'h9fdc589d)), int'(32'hf20a225c));
        chk_int("imc_01010101", int'(inv_mix_column(32'h01010101)), int'(32'h01010101));

        tick();
        chk_int("ready_valid_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_cipher_seq.md
Name: inv_cipher_seq

Overview:
- Iterative AES inverse cipher: decrypts one 128-bit block, one round per clock.
- Performs the decrypt direction of the encrypt datapath. Contains InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
- Sits beside the encrypt core in the AES accelerator. Fetches round keys by index from the shared expanded-key register file, read combinationally.
- Valid/ready handshake on both input and output.

Parameters:
- NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256). Key width is handled by the key store, not this block.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous, active-high reset
- in_valid_i  input  1  ciphertext block offered
- in_ready_o  output  1  block accepted when in_valid_i & in_ready_o at rising edge
- data_i  input  128  ciphertext; word0 = [127:96], byte0 = [127:120], column-major per FIPS-197
- rk_idx_o  output  4  round-key index requested this cycle
- rk_i  input  128  round key for rk_idx_o, valid same cycle (combinational read)
- out_valid_o  output  1  plaintext valid
- out_ready_i  input  1  consumer accepts plaintext
- data_o  output  128  plaintext, same byte order as data_i
- busy_o  output  1  high in ROUND or DONE

Behaviour:
- Reset values: state register 0, round counter NR-1, FSM IDLE, in_ready_o=1, out_valid_o=0, data_o=0, busy_o=0, rk_idx_o=NR.
- FSM has three states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready_o=1, rk_idx_o=NR.
  - On handshake: state <= data_i ^ rk_i, round counter r <= NR-1, go to ROUND.
- ROUND:
  - in_ready_o=0, rk_idx_o=r.
  - If r != 0: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_i), then r <= r-1.
  - If r == 0 (final round, no InvMixColumns): state <= InvSubBytes(InvShiftRows(state)) ^ rk_i, go to DONE.
- DONE:
  - out_valid_o=1, data_o=state, held stable until out_ready_i.
  - On out_ready_i, go to IDLE next cycle. There is no same-cycle re-accept.
- Latency and throughput:
  - Handshake at edge E0 → out_valid_o high after edge E(NR).
  - Minimum block spacing is NR+2 cycles.
- InvShiftRows, with state words w0..w3, where row n is byte [31-8n:24-8n] of each word:
  - v0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]}
  - v1 = {w1[31:24], w0[23:16], w3[15:8], w2[7:0]}
  - v2 = {w2[31:24], w1[23:16], w0[15:8], w3[7:0]}
  - v3 = {w3[31:24], w2[23:16], w1[15:8], w0[7:0]}
- InvMixColumns:
  - Per column, multiply by the matrix {0e,0b,0d,09} (circulant).
  - GF(2^8) arithmetic uses reduction polynomial 0x11B, built from repeated xtime. No lookup tables for multiplies.
- Boundary conditions:
  - in_valid_i while not IDLE: ignored, data_i not sampled.
  - rk_i is sampled only in IDLE-handshake and ROUND cycles.
  - out_ready_i outside DONE: ignored.
  - out_valid_o and in_ready_o are never high together.
  - Asynchronous reset mid-ROUND or mid-DONE: immediate return to reset values; the block in flight is discarded.
  - in_valid_i may drop without handshake in IDLE with no effect.
- All outputs come from registers or FSM-state decode. There is no combinational path from in_valid_i or out_ready_i to any output.

Decomposition:
- Shared package aes_pkg holds:
  - constants NB=4 and the NR default
  - FSM state enum (IDLE, ROUND, DONE)
  - functions xtime, gmul (9, 11, 13, 14), inv_shift_rows, inv_mix_column
  - These are shared later with a key-expansion or encrypt-side refactor.
- One sub-module, inv_subbytes: 128-bit combinational map of 16 instances of a 256-entry inverse S-box case table.

Test Plan:
- FIPS-197 App. C.1 (keys from key 000102030405060708090a0b0c0d0e0f; rk[10]=13111d7fe3944a17f307a78b4d2b30c5):
  - Stimulus: data_i=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: data_o=00112233445566778899aabbccddeeff, out_valid_o rises exactly 10 cycles after the handshake.
  - rk_idx_o sequence: 10,9,...,0.
- FIPS-197 App. B (key 2b7e151628aed2a6abf7158809cf4f3c):
  - Stimulus: data_i=3925841d02dc09fbdc118597196a0b32.
  - Required: data_o=3243f6a8885a308d313198a2e0370734.
- Back-pressure:
  - Stimulus: hold out_ready_i=0 for 5 cycles after out_valid_o.
  - Required: data_o stable, in_ready_o=0. Release → in_ready_o=1 on the next cycle. A second block issued immediately decrypts correctly.
- Busy-input rejection:
  - Stimulus: pulse in_valid_i with a different data_i at cycles 3 and 7 of ROUND.
  - Required: result unchanged (App. C.1 plaintext); no second result is produced.
- Reset mid-operation:
  - Stimulus: assert reset_i asynchronously at round counter r=5, between edges.
  - Required: out_valid_o=0, in_ready_o=1, data_o=0 immediately. The next block after release decrypts correctly.
- InvMixColumns unit check via package function:
  - 8e4da1bc → db135345.
  - 9fdc589d → f20a225c.
  - 01010101 → 01010101.
